mem_port_responder: RTL
=======================

Name: mem_port_responder

Overview:
- Slave end of the CPU memory-port handshake (read/write/wmask/address/wdata in; resp/rdata out).
- Backs either CPU port (instruction port A or data port B) with an internal word array and a fixed, parameterised response latency.
- Used as the synthesizable memory model behind the pipeline and mem_indirect in simulation and FPGA bring-up.
- Also flags initiator protocol violations.

Parameters:
- LATENCY, 3, cycles from first request cycle to the resp cycle; legal range 1..15.
- ADDR_BITS, 10, word-index width; array holds 2**ADDR_BITS 16-bit words.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- read  input  1  read request, held by initiator until resp
- write  input  1  write request, held by initiator until resp
- wmask  input  2  byte enables; bit0 = data[7:0], bit1 = data[15:8]
- address  input  16  byte address; address[0] ignored for array indexing
- wdata  input  16  write data, held with write
- resp  output  1  single-cycle completion pulse
- rdata  output  16  read data, valid only while resp=1
- proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Word index = address[ADDR_BITS:1]; higher address bits ignored (aliasing).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - read|write sampled high at an edge -> latch address, wdata, wmask and op (write if write=1, else read); load counter with LATENCY-1.
  - LATENCY=1 -> go directly to RESP; otherwise go to WAIT.
- WAIT:
  - Decrement counter each cycle; counter reaching 0 -> RESP.
  - Must check every cycle that the request is unchanged (see violations below).
- Edge entering RESP:
  - Read: rdata <= array[idx].
  - Write: array[idx] bytes updated per latched wmask; rdata <= pre-write word.
  - resp <= 1.
- RESP: lasts exactly one cycle; resp=1, rdata stable. Next edge -> IDLE, resp <= 0, rdata <= 0.
- Timing: request first high in cycle t -> resp high in cycle t+LATENCY, low in t+LATENCY+1.
- A request still asserted in the cycle after resp is a new transaction, accepted at the next IDLE sample. Back-to-back throughput is one access per LATENCY+1 cycles.
- read and write both high: treated as write; rdata returns the pre-write word.
- wmask=00 write: array unchanged; resp still pulses.
- Protocol violation, checked in WAIT only:
  - Triggers: read and write both low, op changes, address changes, or (write op) wdata/wmask changes before resp.
  - Response: abort to IDLE with no array update and no resp; proto_err <= 1 (sticky until reset).
- Reset (any state, including mid-transaction):
  - State -> IDLE; resp=0, rdata=0, proto_err=0, counter=0.
  - Any in-flight write is dropped.
  - Array contents are not reset.
- Array has no initial value; the bench preloads it through hierarchical $readmemh.

Test Plan:
- Reset, LATENCY=3; write addr 0x0040 wdata 0xBEEF wmask 11 held from cycle 1 -> resp=1 only in cycle 4; then read 0x0040 from cycle 6 -> resp in cycle 9 with rdata=0xBEEF; rdata=0 in cycle 10.
- Byte masks: word 0x0040=0xBEEF; write wdata 0x1234 wmask 01 -> word 0xBE34; write wdata 0x5600 wmask 10 -> word 0x5634; read 0x0041 (odd byte address) -> rdata 0x5634.
- LATENCY=1: read held continuously for 6 cycles -> resp pulses in cycles 2, 4, 6 (one per two cycles), never two consecutive resp cycles.
- Aliasing/wrap: ADDR_BITS=10, write 0xAAAA to 0x0000, read 0x0800 -> rdata 0xAAAA; read 0xFFFE -> word index 1023.
- Violation: read 0x0010 asserted, address changed to 0x0012 in the second cycle (WAIT) -> no resp, proto_err=1 and stays 1 through later good transactions until reset; a write aborted the same way leaves the array unchanged.
- Reset mid-write at WAIT counter=1 -> next cycle resp=0, rdata=0, state IDLE; read back same address returns the old value; simultaneous read+write 0x0020 (old 0x0001, wdata 0x00FF) -> resp with rdata 0x0001, later read returns 0x00FF.

Source files
------------

// File: rtl/mem_port_responder.sv
// Word-array memory answering the CPU memory-port handshake after a fixed LATENCY.
// Request must be held unchanged until resp; any change mid-wait aborts and sets sticky proto_err.
module mem_port_responder #(
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  wmask,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  output logic        resp,
  output logic [15:0] rdata,
  output logic        proto_err
);
  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic                   op_wr_q;
  logic [15:0]            addr_q;
  logic [15:0]            wdata_q;
  logic [1:0]             wmask_q;
  logic [15:0]            mem_q [DEPTH];

  logic                   req;
  logic                   changed;
  logic                   fire_d;
  logic                   acc_wr_d;
  logic [ADDR_BITS-1:0]   acc_idx_d;
  logic [15:0]            acc_wdata_d;
  logic [1:0]             acc_mask_d;
  logic [15:0]            old_word_d;
  logic [15:0]            new_word_d;

  assign req = read | write;

  always_comb begin
    changed = !req || (write != op_wr_q) || (address != addr_q) ||
              (op_wr_q && ((wdata != wdata_q) || (wmask != wmask_q)));
    // With LATENCY=1 the access commits on the accepting edge, so use the live request.
    if (state_q == IDLE) begin
      acc_wr_d    = write;
      acc_idx_d   = address[ADDR_BITS:1];
      acc_wdata_d = wdata;
      acc_mask_d  = wmask;
    end else begin
      acc_wr_d    = op_wr_q;
      acc_idx_d   = addr_q[ADDR_BITS:1];
      acc_wdata_d = wdata_q;
      acc_mask_d  = wmask_q;
    end
    fire_d = ((state_q == IDLE) && req && (LATENCY == 1)) ||
             ((state_q == WAIT) && !changed && (cnt_q == 4'd1));
    old_word_d = mem_q[acc_idx_d];
    new_word_d = {acc_mask_d[1] ? acc_wdata_d[15:8] : old_word_d[15:8],
                  acc_mask_d[0] ? acc_wdata_d[7:0]  : old_word_d[7:0]};
  end

  // Array is never reset; a reset on the commit edge drops the in-flight write.
  always_ff @(posedge clk) begin
    if (!reset && fire_d && acc_wr_d) begin
      mem_q[acc_idx_d] <= new_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      resp      <= 1'b0;
      rdata     <= 16'h0000;
      proto_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp  <= 1'b0;
          rdata <= 16'h0000;
          if (req) begin
            op_wr_q <= write;
            addr_q  <= address;
            wdata_q <= wdata;
            wmask_q <= wmask;
            cnt_q   <= CNT_LOAD;
            if (LATENCY == 1) begin
              state_q <= RESP;
              resp    <= 1'b1;
              rdata   <= old_word_d;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (changed) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            proto_err <= 1'b1;
          end else if (cnt_q == 4'd1) begin
            state_q <= RESP;
            cnt_q   <= 4'd0;
            resp    <= 1'b1;
            rdata   <= old_word_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          resp    <= 1'b0;
          rdata   <= 16'h0000;
        end
        default: begin
          state_q <= IDLE;
          resp    <= 1'b0;
          rdata   <= 16'h0000;
        end
      endcase
    end
  end
endmodule
